// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/MEM single-port memory bus arbiter.
package mem_bus_arbiter_pkg;

   localparam int unsigned ARB_STATE_W = 3;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE      = 3'd0,
      ARB_GNT_INST  = 3'd1,
      ARB_GNT_DATA  = 3'd2,
      ARB_DONE_INST = 3'd3,
      ARB_DONE_DATA = 3'd4
   } arb_state_e;

   // Which requester received the most recent grant (round-robin pointer).
   typedef enum logic {
      LAST_INST = 1'b0,
      LAST_DATA = 1'b1
   } arb_last_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant select between fetch and data requests; ARB_RR_EN selects round-robin,
// otherwise data has fixed priority over fetch.
module mem_arb_pick
   import mem_bus_arbiter_pkg::*;
(
   input  logic      inst_req_i,
   input  logic      data_req_i,
`ifdef ARB_RR_EN
   input  arb_last_e last_gnt_i,
`endif
   output logic      gnt_inst_o,
   output logic      gnt_data_o
);

   always_comb begin
      gnt_data_o = data_req_i;
`ifdef ARB_RR_EN
      // On a tie the requester that was not served last goes first.
      if (inst_req_i && data_req_i && (last_gnt_i == LAST_DATA)) begin
         gnt_data_o = 1'b0;
      end
`endif
      gnt_inst_o = inst_req_i & ~gnt_data_o;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between IF (fetch) and MEM (data) requesters.
// Optional round-robin arbitration is built when ARB_RR_EN is defined.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req_i,
   input  logic [ADDR_W-1:0]   inst_addr_i,
   output logic                inst_ack_o,
   output logic [DATA_W-1:0]   inst_rdata_o,
   input  logic                data_req_i,
   input  logic                data_we_i,
   input  logic [ADDR_W-1:0]   data_addr_i,
   input  logic [DATA_W/8-1:0] data_sel_i,
   input  logic [DATA_W-1:0]   data_wdata_i,
   output logic                data_ack_o,
   output logic [DATA_W-1:0]   data_rdata_o,
   input  logic                flush_i,
   output logic                stallreq_inst_o,
   output logic                stallreq_data_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [DATA_W/8-1:0] bus_sel_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   input  logic [DATA_W-1:0]   bus_rdata_i,
   input  logic                bus_ack_i
);

   localparam int unsigned SEL_W = DATA_W / 8;

   arb_state_e        state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              inst_ack_q, inst_ack_d;
   logic              data_ack_q, data_ack_d;
   logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
   logic              flushed_q, flushed_d;
   logic              gnt_inst, gnt_data;
`ifdef ARB_RR_EN
   arb_last_e         last_q, last_d;
`endif

   mem_arb_pick u_pick (
      .inst_req_i (inst_req_i),
      .data_req_i (data_req_i),
`ifdef ARB_RR_EN
      .last_gnt_i (last_q),
`endif
      .gnt_inst_o (gnt_inst),
      .gnt_data_o (gnt_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_sel_q    <= '0;
         bus_wdata_q  <= '0;
         inst_ack_q   <= 1'b0;
         data_ack_q   <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         flushed_q    <= 1'b0;
`ifdef ARB_RR_EN
         last_q       <= LAST_INST;
`endif
      end else begin
         state_q      <= state_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_sel_q    <= bus_sel_d;
         bus_wdata_q  <= bus_wdata_d;
         inst_ack_q   <= inst_ack_d;
         data_ack_q   <= data_ack_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         flushed_q    <= flushed_d;
`ifdef ARB_RR_EN
         last_q       <= last_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_sel_d    = bus_sel_q;
      bus_wdata_d  = bus_wdata_q;
      inst_ack_d   = 1'b0;
      data_ack_d   = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      flushed_d    = flushed_q;
`ifdef ARB_RR_EN
      last_d       = last_q;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (gnt_data) begin
               state_d     = ARB_GNT_DATA;
               bus_req_d   = 1'b1;
               bus_we_d    = data_we_i;
               bus_addr_d  = data_addr_i;
               bus_sel_d   = data_sel_i;
               bus_wdata_d = data_wdata_i;
`ifdef ARB_RR_EN
               last_d      = LAST_DATA;
`endif
            end else if (gnt_inst) begin
               state_d     = ARB_GNT_INST;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = inst_addr_i;
               bus_sel_d   = {SEL_W{1'b1}};
               bus_wdata_d = '0;
               flushed_d   = 1'b0;
`ifdef ARB_RR_EN
               last_d      = LAST_INST;
`endif
            end
         end
         ARB_GNT_INST: begin
            // A flush anywhere in the grant window discards the fetched word.
            if (flush_i) begin
               flushed_d = 1'b1;
            end
            if (bus_ack_i) begin
               state_d   = ARB_DONE_INST;
               bus_req_d = 1'b0;
               if (!(flushed_q || flush_i)) begin
                  inst_ack_d   = 1'b1;
                  inst_rdata_d = bus_rdata_i;
               end
            end
         end
         ARB_GNT_DATA: begin
            if (bus_ack_i) begin
               state_d    = ARB_DONE_DATA;
               bus_req_d  = 1'b0;
               bus_we_d   = 1'b0;
               data_ack_d = 1'b1;
               if (!bus_we_q) begin
                  data_rdata_d = bus_rdata_i;
               end
            end
         end
         ARB_DONE_INST, ARB_DONE_DATA: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d   = ARB_IDLE;
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
         end
      endcase
   end

   assign inst_ack_o      = inst_ack_q;
   assign inst_rdata_o    = inst_rdata_q;
   assign data_ack_o      = data_ack_q;
   assign data_rdata_o    = data_rdata_q;
   assign bus_req_o       = bus_req_q;
   assign bus_we_o        = bus_we_q;
   assign bus_addr_o      = bus_addr_q;
   assign bus_sel_o       = bus_sel_q;
   assign bus_wdata_o     = bus_wdata_q;
   assign stallreq_inst_o = inst_req_i & ~inst_ack_q;
   assign stallreq_data_o = data_req_i & ~data_ack_q;

endmodule
